// File: rtl/rom_reader.sv
// Sequential ROM read initiator: start -> READ/LATCH per word, first word valid 3 cycles after start, 1 word / 2 cycles.
// Back-pressure: a held output word stalls the FSM in LATCH; done pulses after the last word is accepted.
module rom_reader #(
  parameter int AW = 4,
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic [AW:0]   count,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] rom_addr,
  output logic          rom_rd,
  input  logic [DW-1:0] rom_data,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  input  logic          dout_ready
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_LATCH = 2'd2,
    S_FLUSH = 2'd3
  } state_e;

  localparam logic [AW:0] LAST_WORD = (AW+1)'(1);

  state_e        state_q;
  logic [AW-1:0] addr_q;
  logic [AW:0]   remaining_q;
  logic          busy_q;
  logic          done_q;
  logic [AW-1:0] rom_addr_q;
  logic          rom_rd_q;
  logic [DW-1:0] dout_q;
  logic          dout_valid_q;

  logic [AW-1:0] addr_d;
  logic [AW:0]   remaining_d;
  logic          accept;
  logic          slot_free;

  // Address naturally wraps at 2^AW.
  assign addr_d      = addr_q + AW'(1);
  assign remaining_d = remaining_q - LAST_WORD;
  assign accept      = dout_valid_q && dout_ready;
  assign slot_free   = !dout_valid_q || dout_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      remaining_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rom_addr_q   <= '0;
      rom_rd_q     <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // A reload in LATCH below overrides this clear for back-to-back transfers.
      if (accept) dout_valid_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (count != '0) begin
              addr_q      <= start_addr;
              remaining_q <= count;
              rom_addr_q  <= start_addr;
              rom_rd_q    <= 1'b1;
              busy_q      <= 1'b1;
              state_q     <= S_READ;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        S_READ: begin
          state_q <= S_LATCH;
        end
        S_LATCH: begin
          if (slot_free) begin
            dout_q       <= rom_data;
            dout_valid_q <= 1'b1;
            addr_q       <= addr_d;
            remaining_q  <= remaining_d;
            if (remaining_q == LAST_WORD) begin
              rom_rd_q <= 1'b0;
              state_q  <= S_FLUSH;
            end else begin
              rom_addr_q <= addr_d;
              state_q    <= S_READ;
            end
          end
        end
        S_FLUSH: begin
          if (accept) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign rom_addr   = rom_addr_q;
  assign rom_rd     = rom_rd_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_rom_reader.sv
// Bench for rom_reader: ROM[i]=i model, queue scoreboard of expected words, per-run timing checks.
module tb_rom_reader;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] start_addr;
  logic [4:0] count;
  logic       busy;
  logic       done;
  logic [3:0] rom_addr;
  logic       rom_rd;
  logic [3:0] rom_data;
  logic [3:0] dout;
  logic       dout_valid;
  logic       dout_ready;

  int errors = 0;
  int checks = 0;

  logic [3:0] exp_q[$];
  logic [3:0] exp_word;
  logic       prev_valid = 1'b0;
  logic       prev_ready = 1'b0;
  logic [3:0] prev_dout  = 4'h0;

  rom_reader #(.AW(4), .DW(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
    .count      (count),
    .busy       (busy),
    .done       (done),
    .rom_addr   (rom_addr),
    .rom_rd     (rom_rd),
    .rom_data   (rom_data),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready)
  );

  assign rom_data = rom_rd ? rom_addr : 4'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer plus hold-stability check on the output stream.
  always @(negedge clk) begin
    if (dout_valid && dout_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_extra_word", exp_q.size(), 1);
      end else begin
        exp_word = exp_q.pop_front();
        chk("dout_word", {28'h0, dout}, {28'h0, exp_word});
      end
    end
    if (prev_valid && !prev_ready && dout_valid)
      chk("dout_hold", {28'h0, dout}, {28'h0, prev_dout});
    prev_valid = dout_valid;
    prev_ready = dout_ready;
    prev_dout  = dout;
  end

  task automatic do_run(input logic [3:0] sa, input logic [4:0] cnt, input int stall, input bit inj);
    int fv;
    int dc;
    int dn;
    int lasths;
    int rd_seen;
    fv = 0; dc = 0; dn = 0; lasths = 0; rd_seen = 0;
    for (int i = 0; i < int'(cnt); i++) exp_q.push_back(4'(int'(sa) + i));
    start      = 1'b1;
    start_addr = sa;
    count      = cnt;
    dout_ready = (stall == 0);
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 1; k <= 80 && (dc == 0 || k <= dc + 3); k++) begin
      @(negedge clk);
      if (dout_valid && fv == 0) fv = k;
      if (rom_rd) rd_seen++;
      if (done) begin
        dn++;
        if (dc == 0) dc = k;
      end
      if (k == 1) chk("busy_cycle1", {31'h0, busy}, {31'h0, cnt != 0});
      if (dc != 0 && k == dc) chk("busy_at_done", {31'h0, busy}, 0);
      if (dc != 0 && k > dc) begin
        chk("idle_rom_rd", {31'h0, rom_rd}, 0);
        chk("idle_valid", {31'h0, dout_valid}, 0);
      end
      if (stall == 0 && dout_valid && dout_ready) begin
        if (lasths != 0) chk("word_gap", k - lasths, 2);
        lasths = k;
      end
      if (stall > 0 && fv != 0 && k == fv + stall - 1) begin
        chk("stall_rom_rd", {31'h0, rom_rd}, 1);
        chk("stall_addr", {28'h0, rom_addr}, {28'h0, 4'(sa + 4'd1)});
        chk("stall_dout", {28'h0, dout}, {28'h0, sa});
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (inj && k == 3) begin
        start      = 1'b1;
        start_addr = 4'd9;
        count      = 5'd5;
      end
      dout_ready = (stall == 0) || (fv != 0 && k + 1 >= fv + stall);
    end
    chk("done_seen", {31'h0, dc != 0}, 1);
    chk("done_count", dn, 1);
    if (stall == 0 && cnt != 0) begin
      chk("first_valid_cyc", fv, 3);
      chk("done_cyc", dc, 2 * int'(cnt) + 2);
    end
    if (cnt == 0) begin
      chk("done_cyc_zero", dc, 1);
      chk("no_rom_rd", rd_seen, 0);
    end
    chk("sb_empty", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int dseen;
    rst_n      = 1'b0;
    start      = 1'b0;
    start_addr = 4'h0;
    count      = 5'h0;
    dout_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'h0, busy}, 0);
    chk("rst_done", {31'h0, done}, 0);
    chk("rst_rom_rd", {31'h0, rom_rd}, 0);
    chk("rst_rom_addr", {28'h0, rom_addr}, 0);
    chk("rst_dout", {28'h0, dout}, 0);
    chk("rst_valid", {31'h0, dout_valid}, 0);
    @(posedge clk);
    #1;
    rst_n      = 1'b1;
    dout_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_rom_rd0", {31'h0, rom_rd}, 0);
    chk("idle_busy0", {31'h0, busy}, 0);
    chk("idle_done0", {31'h0, done}, 0);
    @(posedge clk);
    #1;

    do_run(4'd2, 5'd3, 0, 1'b0);
    do_run(4'd14, 5'd16, 0, 1'b0);
    do_run(4'd6, 5'd0, 0, 1'b0);
    do_run(4'd10, 5'd4, 6, 1'b0);
    do_run(4'd3, 5'd4, 0, 1'b1);

    // Abandon a run while its second word is on the output.
    for (int i = 0; i < 4; i++) exp_q.push_back(4'(5 + i));
    start      = 1'b1;
    start_addr = 4'd5;
    count      = 5'd4;
    dout_ready = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_valid", {31'h0, dout_valid}, 1);
    chk("mid_word2", {28'h0, dout}, 28'h0 + 32'd6);
    rst_n = 1'b0;
    #1;
    chk("arst_rom_rd", {31'h0, rom_rd}, 0);
    chk("arst_valid", {31'h0, dout_valid}, 0);
    chk("arst_busy", {31'h0, busy}, 0);
    chk("arst_rom_addr", {28'h0, rom_addr}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    dseen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done) dseen++;
    end
    chk("arst_no_done", dseen, 0);
    @(posedge clk);
    #1;
    do_run(4'd7, 5'd2, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1);
  end

endmodule
